// File: rtl/mulu_m3q3_acc_if.sv
// Product/control bundle between the multiplier-side driver and the signed accumulator.
// The master drives terms and run control; the slave returns the registered total and status.
interface mulu_m3q3_acc_if #(
  parameter int P_WIDTH   = 6,
  parameter int ACC_WIDTH = 10,
  parameter int CNT_WIDTH = 4
);
  logic [P_WIDTH-1:0]   p;
  logic                 s;
  logic                 rdy;
  logic                 start;
  logic [CNT_WIDTH-1:0] len;
  logic [ACC_WIDTH-1:0] acc;
  logic                 busy;
  logic                 done;
  logic                 ovf;

  modport master (output p, s, rdy, start, len, input acc, busy, done, ovf);
  modport slave  (input p, s, rdy, start, len, output acc, busy, done, ovf);
endinterface

// File: rtl/mulu_m3q3_acc.sv
// Signed accumulator: sums len sign/magnitude terms into a wrapping two's-complement total.
// Latency 1 cycle per term; one term per clock on rdy, no backpressure (rdy outside ACCUM is dropped).
module mulu_m3q3_acc #(
  parameter int P_WIDTH   = 6,
  parameter int ACC_WIDTH = 10,
  parameter int CNT_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  mulu_m3q3_acc_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH:0]   remaining;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 ovf_q;
  logic                 busy_q;
  logic                 done_q;

  logic [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH-1:0] sum;
  logic                 sum_ovf;
  logic [CNT_WIDTH:0]   len_ext;

  always_comb begin
    term = {{(ACC_WIDTH-P_WIDTH){1'b0}}, bus.p};
    if (bus.s) begin
      term = -term;
    end
    sum     = acc_q + term;
    // A negated zero stays zero, so s=1,p=0 can never flag overflow here.
    sum_ovf = (acc_q[ACC_WIDTH-1] == term[ACC_WIDTH-1]) &&
              (sum[ACC_WIDTH-1]   != acc_q[ACC_WIDTH-1]);
    len_ext = (bus.len == '0) ? {1'b1, {CNT_WIDTH{1'b0}}} : {1'b0, bus.len};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state     <= ACCUM;
            remaining <= len_ext;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        ACCUM: begin
          if (bus.rdy) begin
            acc_q     <= sum;
            ovf_q     <= ovf_q | sum_ovf;
            remaining <= remaining - 1'b1;
            if (remaining == {{CNT_WIDTH{1'b0}}, 1'b1}) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc  = acc_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_mulu_m3q3_acc.sv
// Bench for mulu_m3q3_acc: directed scenarios plus random runs against an integer-arithmetic model.
module tb_mulu_m3q3_acc;
  localparam int P_W = 6;
  localparam int A_W = 10;
  localparam int C_W = 4;
  localparam int AMAX = 2**(A_W-1) - 1;
  localparam int AMIN = -(2**(A_W-1));

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mulu_m3q3_acc_if #(.P_WIDTH(P_W), .ACC_WIDTH(A_W), .CNT_WIDTH(C_W)) bus ();

  mulu_m3q3_acc #(.P_WIDTH(P_W), .ACC_WIDTH(A_W), .CNT_WIDTH(C_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: true integer total folded into the signed range; overflow when the exact sum leaves it.
  int m_acc, m_rem;
  bit m_busy, m_done, m_ovf;

  task automatic model_reset();
    m_acc = 0; m_rem = 0; m_busy = 0; m_done = 0; m_ovf = 0;
  endtask

  task automatic model_step();
    int t, raw;
    if (m_busy) begin
      if (bus.rdy) begin
        t   = bus.s ? -int'(bus.p) : int'(bus.p);
        raw = m_acc + t;
        if (raw > AMAX || raw < AMIN) m_ovf = 1;
        m_acc = raw;
        while (m_acc > AMAX) m_acc -= 2**A_W;
        while (m_acc < AMIN) m_acc += 2**A_W;
        m_rem--;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end
    end else if (bus.start) begin
      m_acc = 0; m_ovf = 0; m_busy = 1; m_done = 0;
      m_rem = (bus.len == 0) ? 2**C_W : int'(bus.len);
    end
  endtask

  function automatic logic [A_W+2:0] exp_vec();
    logic [31:0] a;
    a = m_acc;
    return {a[A_W-1:0], m_busy, m_done, m_ovf};
  endfunction

  function automatic logic [A_W+2:0] dut_vec();
    return {bus.acc, bus.busy, bus.done, bus.ovf};
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit st, input int ln, input bit r, input int mag, input bit sg);
    bus.start = st;
    bus.len   = C_W'(ln);
    bus.rdy   = r;
    bus.p     = P_W'(mag);
    bus.s     = sg;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", dut_vec());
    end
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 1, 5, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (dut_vec() !== '0) begin
        failures++;
        $display("FAIL idle_rdy_ignored cyc=%0d got=%h exp=0", i, dut_vec());
      end
    end
  endtask

  task automatic test_basic_sum();
    int mags[3] = '{9, 4, 36};
    bit sgns[3] = '{0, 1, 0};
    drive(1, 3, 1, 7, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, mags[i], sgns[i]);
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL basic_term%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.acc !== 10'd41 || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic_final acc=%0d done=%b busy=%b ovf=%b exp acc=41 done=1 busy=0 ovf=0",
               bus.acc, bus.done, bus.busy, bus.ovf);
    end
    drive(0, 0, 1, 20, 0);
    cycle();
    checks++;
    if (bus.acc !== 10'd41 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL done_holds acc=%0d done=%b exp acc=41 done=1", bus.acc, bus.done);
    end
  endtask

  task automatic test_gapped();
    drive(1, 2, 0, 0, 0);
    cycle();
    for (int c = 1; c <= 7; c++) begin
      drive(0, 0, (c == 2 || c == 7), 1, 0);
      cycle();
      checks++;
      if (c < 7 && (bus.busy !== 1'b1 || bus.done !== 1'b0)) begin
        failures++;
        $display("FAIL gapped_busy cyc=%0d busy=%b done=%b exp busy=1 done=0", c, bus.busy, bus.done);
      end else if (c == 7 && (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.acc !== 10'd2)) begin
        failures++;
        $display("FAIL gapped_done busy=%b done=%b acc=%0d exp busy=0 done=1 acc=2",
                 bus.busy, bus.done, bus.acc);
      end
    end
  endtask

  task automatic test_overflow_wrap();
    drive(1, 0, 0, 0, 0);
    cycle();
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 1, 63, 0);
      cycle();
      checks++;
      if (bus.ovf !== (i >= 9) || dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL ovf_term%0d ovf=%b got=%h exp_ovf=%b exp=%h", i, bus.ovf, dut_vec(), (i >= 9), exp_vec());
      end
    end
    checks++;
    if (bus.acc !== 10'h3F0 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL wrap_final acc=%h done=%b exp acc=3f0 done=1", bus.acc, bus.done);
    end
  endtask

  task automatic test_restart();
    drive(1, 1, 1, 9, 0);
    cycle();
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.acc !== '0 || bus.ovf !== 1'b0) begin
      failures++;
      $display("FAIL restart_state busy=%b done=%b acc=%h ovf=%b exp 1 0 000 0", bus.busy, bus.done, bus.acc, bus.ovf);
    end
    drive(1, 5, 0, 0, 0);
    cycle();
    checks++;
    if (dut_vec() !== exp_vec() || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL start_in_accum got=%h exp=%h", dut_vec(), exp_vec());
    end
    drive(0, 0, 1, 1, 1);
    cycle();
    checks++;
    if (bus.acc !== 10'h3FF || bus.ovf !== 1'b0 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL restart_neg acc=%h ovf=%b done=%b exp 3ff 0 1", bus.acc, bus.ovf, bus.done);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 4, 0, 0, 0);
    cycle();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 10, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0);
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== '0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=0", dut_vec());
    end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 11, 0);
      cycle();
      checks++;
      if (dut_vec() !== '0) begin
        failures++;
        $display("FAIL post_reset_rdy cyc=%0d got=%h exp=0", i, dut_vec());
      end
    end
  endtask

  task automatic test_back_to_back_random();
    int guard;
    for (int run = 0; run < 12; run++) begin
      drive(1, $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1));
      cycle();
      guard = 0;
      while (m_busy && guard < 200) begin
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0,
              $urandom_range(0, 63), $urandom_range(0, 1));
        cycle();
        guard++;
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL random run=%0d cyc=%0d got=%h exp=%h", run, guard, dut_vec(), exp_vec());
        end
      end
      checks++;
      if (guard >= 200 || bus.done !== 1'b1) begin
        failures++;
        $display("FAIL random_done run=%0d done=%b cycles=%0d", run, bus.done, guard);
      end
      if (run % 3 == 2) begin
        drive(0, 0, 1, 33, 1);
        cycle();
        checks++;
        if (dut_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL random_hold run=%0d got=%h exp=%h", run, dut_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_gapped();
    test_overflow_wrap();
    test_restart();
    test_reset_mid();
    test_back_to_back_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mulu_m3q3_acc.md
# mulu_m3q3_acc

Signed accumulator stage downstream of the `mulu_m3q3` multiplier. Consumes the product magnitude `p`, sign `s` and `rdy` strobe, sums a programmed number of signed terms into a two's-complement accumulator, and presents the registered total with `done`/`busy` status and a sticky overflow flag. Together with the multiplier it forms a small multiply-accumulate (dot-product) datapath for the tile.

## Interface
- `P_WIDTH`, 6: product magnitude width; the magnitude is unsigned.
- `ACC_WIDTH`, 10: accumulator width, two's complement; must be greater than `P_WIDTH`.
- `CNT_WIDTH`, 4: term-count width; a run holds 1..2^CNT_WIDTH terms.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; forces every register to its reset value immediately.
- `p` input P_WIDTH: product magnitude from the multiplier.
- `s` input 1: product sign; 1 means negative.
- `rdy` input 1: product-valid strobe; one term per cycle in which it is high.
- `start` input 1: begins a new run.
- `len` input CNT_WIDTH: number of terms, sampled when a run starts; 0 encodes 2^CNT_WIDTH.
- `acc` output ACC_WIDTH: registered accumulator value.
- `busy` output 1: high while in ACCUM.
- `done` output 1: high while in DONE.
- `ovf` output 1: sticky signed-overflow flag for the current run.

## Operation
- States:
  - IDLE: reset state.
  - ACCUM: terms are being summed.
  - DONE: the run has finished and the result is held.
- IDLE with `start`=1:
  - `acc`←0, `ovf`←0, remaining←`len` (0 becomes 2^CNT_WIDTH).
  - Next state is ACCUM.
  - `rdy` in the same cycle is ignored.
- ACCUM with `rdy`=1:
  - term = `s` ? −zext(`p`) : +zext(`p`), sign-extended to ACC_WIDTH.
  - `acc`←`acc`+term, truncated to ACC_WIDTH (wraps).
  - remaining decrements by 1.
  - When the accepted term is the last one (remaining==1), next state is DONE.
- ACCUM with `rdy`=0: hold all state.
- `start` in ACCUM is ignored; a run cannot be restarted except by `reset`.
- Overflow: if the operands share a sign and the result sign differs, `ovf`←1. It stays 1 until the next run starts.
- `s`=1 with `p`=0 is a zero term and is never an overflow.
- DONE:
  - `acc` and `ovf` are held; `rdy` is ignored.
  - `start`=1 clears state, loads `len` and goes directly to ACCUM, with no IDLE cycle.
- IDLE: `rdy` is ignored, and `acc` keeps its last value (0 after reset).
- Reset value of every output is 0. The FSM resets to IDLE and remaining resets to 0.
- Reset asserted mid-run aborts the run. No partial result or `done` is produced afterwards.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- `busy` rises in the cycle after `start` is sampled.
- A term sampled at edge N is visible on `acc` and `ovf` after edge N; latency is 1 cycle.
- `done` rises on the same edge that registers the last term's sum. `busy` falls on that edge.
- Minimum run time: `len` cycles of `rdy` plus 1 start cycle. Back-to-back `rdy` is fully supported at one term per clock.
- Restart from DONE: `start` at edge N gives `busy`=1, `done`=0, `acc`=0 after edge N.
- Reset deassertion is synchronous to the design: the first `start` is honoured on the first rising edge after `reset` falls.

## Test plan
- Reset then idle: after reset, `acc`=0, `busy`=0, `done`=0, `ovf`=0. Applying `rdy`=1, `p`=5 in IDLE leaves `acc`=0.
- Basic sum: `len`=3, `start`, then terms +9, −4, +36 on consecutive cycles → `acc`=41, `done`=1 one cycle after the third `rdy`, `ovf`=0.
- Gapped strobes: `len`=2, `rdy` high at cycles 2 and 7 only (+1, +1) → `acc`=2. `busy` stays high from cycle 1 to cycle 7, and `done` is first seen after edge 7.
- Overflow and wrap: `len`=0 (16 terms), 16×(+63) → `acc`=1008−1024=−16 (0x3F0), `ovf`=1 from the 9th term onward (8×63=504, 9×63=567>511).
- Restart and ignored start: from DONE, `start` with `len`=1, term −1 → `acc`=0x3FF, `ovf`=0. A `start` pulse during ACCUM changes nothing.
- Reset mid-run: `len`=4, two terms accepted, then `reset` pulsed → all outputs 0 immediately. Further `rdy` pulses are ignored until a new `start`.
